// File: rtl/vec_pe_pkg.sv
// Shared helpers for the PE dot-product datapath: tree sizing, accumulator
// width and the final shift / round / saturate conversion.
package vec_pe_pkg;

    // Widest accumulator / result the conversion helper handles.
    localparam int unsigned MAX_W = 64;

    // Number of registered adder-tree levels for c lanes.
    function automatic int unsigned tree_depth(input int unsigned c);
        return $clog2(c);
    endfunction

    // Lane count rounded up to a power of two; extra lanes are zero.
    function automatic int unsigned pad_lanes(input int unsigned c);
        return 32'd1 << $clog2(c);
    endfunction

    // Full product width plus tree growth plus 8 bits of chunk headroom.
    function automatic int unsigned acc_width(input int unsigned w_x, input int unsigned w_k,
                                              input int unsigned c);
        return w_x + w_k + $clog2(c) + 8;
    endfunction

    localparam int unsigned W_ACC_DEF = acc_width(8, 8, 8);

    typedef struct packed {
        logic                    ovf;
        logic signed [MAX_W-1:0] y;
    } sat_res_t;

    // Round-half-up arithmetic shift, then saturate or wrap to w_y bits.
    // y comes back sign-extended; ovf flags any change of value.
    function automatic sat_res_t sat_round(input logic signed [MAX_W-1:0] sum,
                                           input int unsigned shift,
                                           input logic sat,
                                           input int unsigned w_y);
        logic signed [MAX_W-1:0] half;
        logic signed [MAX_W-1:0] r;
        logic signed [MAX_W-1:0] lim;
        sat_res_t res;
        r = sum;
        if (shift > 0) begin
            half = 64'sd1 <<< (shift - 1);
            r    = (sum + half) >>> shift;
        end
        lim = 64'sd1 <<< (w_y - 1);
        if (sat) begin
            if (r > lim - 64'sd1) begin
                res.y = lim - 64'sd1;
            end else if (r < -lim) begin
                res.y = -lim;
            end else begin
                res.y = r;
            end
        end else begin
            res.y = (r <<< (MAX_W - w_y)) >>> (MAX_W - w_y);
        end
        res.ovf = (res.y != r);
        return res;
    endfunction

endpackage

// File: rtl/vec_add_tree.sv
// Pipelined pairwise adder tree: N leaves (power of two), one register per
// level, valid/last sideband travelling alongside. N=1 is a pass-through.
module vec_add_tree #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic [N-1:0][W-1:0] in_data,
    output logic                out_valid,
    output logic                out_last,
    output logic [W-1:0]        out_data,
    output logic                busy
);

    localparam int unsigned D = $clog2(N);

    if (D == 0) begin : g_pass
        logic unused_pass;
        assign unused_pass = clk ^ rst_n ^ en;
        assign out_valid   = in_valid;
        assign out_last    = in_last;
        assign out_data    = in_data[0];
        assign busy        = 1'b0;
    end else begin : g_tree
        // Heap layout: nodes 0..N-2 are registered sums, N-1..2N-2 are the leaves.
        logic [N-2:0][W-1:0]   node_q;
        logic [2*N-2:0][W-1:0] node_v;
        logic [D-1:0]          vld_q;
        logic [D-1:0]          lst_q;

        // Gather registered internal nodes and raw leaves into one indexable view.
        always_comb begin
            node_v = '0;
            for (int i = 0; i < int'(N) - 1; i++) begin
                node_v[i] = node_q[i];
            end
            for (int j = 0; j < int'(N); j++) begin
                node_v[int'(N) - 1 + j] = in_data[j];
            end
        end

        // Each internal node registers the sum of its two children.
        always_ff @(posedge clk) begin
            if (en) begin
                for (int i = 0; i < int'(N) - 1; i++) begin
                    node_q[i] <= node_v[2*i+1] + node_v[2*i+2];
                end
            end
        end

        // Sideband shift register, one bit per level.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= '0;
                lst_q <= '0;
            end else if (en) begin
                vld_q[0] <= in_valid;
                lst_q[0] <= in_last;
                for (int l = 1; l < int'(D); l++) begin
                    vld_q[l] <= vld_q[l-1];
                    lst_q[l] <= lst_q[l-1];
                end
            end
        end

        assign out_valid = vld_q[D-1];
        assign out_last  = lst_q[D-1];
        assign out_data  = node_v[0];
        assign busy      = |vld_q;
    end

endmodule

// File: rtl/vec_dot_pipe.sv
// Pipelined signed dot-product engine: lane multiply, registered adder tree,
// chunk accumulator and a converting output register with valid/ready.
module vec_dot_pipe
    import vec_pe_pkg::*;
#(
    parameter int unsigned C     = 8,
    parameter int unsigned W_X   = 8,
    parameter int unsigned W_K   = 8,
    parameter int unsigned W_Y   = 8,
    parameter int unsigned W_ACC = acc_width(W_X, W_K, C),
    parameter int unsigned W_SH  = $clog2(W_ACC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [C-1:0][W_X-1:0] x,
    input  logic [C-1:0][W_K-1:0] k,
    input  logic                  in_last,
    input  logic [W_SH-1:0]       cfg_shift,
    input  logic                  cfg_sat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W_Y-1:0]        y,
    output logic                  y_ovf,
    output logic [7:0]            y_chunks,
    output logic                  busy
);

    localparam int unsigned C_PAD = pad_lanes(C);
    localparam int unsigned W_P   = W_X + W_K;

    logic stall;
    logic en;

    logic [C-1:0][W_P-1:0]       prod_q;
    logic                        m_valid_q;
    logic                        m_last_q;
    logic [C_PAD-1:0][W_ACC-1:0] tree_in;

    logic             t_valid;
    logic             t_last;
    logic [W_ACC-1:0] t_data;
    logic             t_busy;

    logic signed [W_ACC-1:0] acc_q;
    logic signed [W_ACC-1:0] sum;
    logic [7:0]              cnt_q;
    sat_res_t                conv;
    logic                    unused_conv;

    logic           out_valid_q;
    logic [W_Y-1:0] y_q;
    logic           ovf_q;
    logic [7:0]     chunks_q;

    // A held, unconsumed result freezes every stage including the accumulator.
    assign stall    = out_valid_q & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall;

    // Stage M control: valid/last of the registered products.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (en) begin
            m_valid_q <= in_valid;
            m_last_q  <= in_valid & in_last;
        end
    end

    // Stage M data: full-width signed lane products.
    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            for (int i = 0; i < int'(C); i++) begin
                prod_q[i] <= W_P'($signed(x[i]) * $signed(k[i]));
            end
        end
    end

    // Sign-extend products into the tree; padding lanes stay zero.
    always_comb begin
        tree_in = '0;
        for (int i = 0; i < int'(C); i++) begin
            tree_in[i] = W_ACC'($signed(prod_q[i]));
        end
    end

    vec_add_tree #(
        .N (C_PAD),
        .W (W_ACC)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (m_valid_q),
        .in_last   (m_last_q),
        .in_data   (tree_in),
        .out_valid (t_valid),
        .out_last  (t_last),
        .out_data  (t_data),
        .busy      (t_busy)
    );

    // acc is cleared after every last beat, so it is already zero for a first chunk.
    always_comb begin
        sum  = acc_q + $signed(t_data);
        conv = sat_round(64'(sum), 32'(cfg_shift), cfg_sat, W_Y);
    end

    assign unused_conv = ^conv.y[MAX_W-1:W_Y];

    // Stage A/O: accumulate non-last chunks, convert and publish on last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            chunks_q    <= '0;
        end else if (en) begin
            out_valid_q <= t_valid & t_last;
            if (t_valid) begin
                if (t_last) begin
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    y_q      <= conv.y[W_Y-1:0];
                    ovf_q    <= conv.ovf;
                    chunks_q <= (cnt_q == 8'hff) ? 8'hff : cnt_q + 8'd1;
                end else begin
                    acc_q <= sum;
                    cnt_q <= (cnt_q == 8'hff) ? 8'hff : cnt_q + 8'd1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign y_ovf     = ovf_q;
    assign y_chunks  = chunks_q;
    assign busy      = m_valid_q | t_busy | out_valid_q | (cnt_q != 8'd0);

endmodule

// File: tb/tb_vec_dot_pipe.sv
// Self-checking bench for vec_dot_pipe (C=4, 8-bit operands and result).
module tb_vec_dot_pipe;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0][7:0] x;
    logic [3:0][7:0] k;
    logic            in_last;
    logic [4:0]      cfg_shift;
    logic            cfg_sat;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      y;
    logic            y_ovf;
    logic [7:0]      y_chunks;
    logic            busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int y;
        bit ovf;
        int ch;
    } res_t;

    typedef struct {
        logic [3:0][7:0] x;
        logic [3:0][7:0] k;
        bit              last;
    } beat_t;

    res_t got_q[$];

    localparam logic [31:0] V1234 = 32'h04030201;
    localparam logic [31:0] ONES  = 32'h01010101;
    localparam logic [31:0] TWOS  = 32'h02020202;

    vec_dot_pipe #(
        .C (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .k         (k),
        .in_last   (in_last),
        .cfg_shift (cfg_shift),
        .cfg_sat   (cfg_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_ovf     (y_ovf),
        .y_chunks  (y_chunks),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Record every result that will be consumed at the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back('{y: int'($signed(y)), ovf: y_ovf, ch: int'(y_chunks)});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic void model(input longint sum, input int sh, input bit sat,
                                  output int ey, output bit eovf);
        longint r;
        longint m;
        if (sh > 0) r = floor_div(sum + 2 ** (sh - 1), 2 ** sh);
        else r = sum;
        if (sat) begin
            if (r > 127) m = 127;
            else if (r < -128) m = -128;
            else m = r;
        end else begin
            m = r % 256;
            if (m < 0) m = m + 256;
            if (m > 127) m = m - 256;
        end
        ey   = int'(m);
        eovf = (m != r);
    endfunction

    function automatic longint dot(input logic [3:0][7:0] xv, input logic [3:0][7:0] kv);
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            s += longint'($signed(xv[i])) * longint'($signed(kv[i]));
        end
        return s;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [3:0][7:0] xv, input logic [3:0][7:0] kv,
                             input logic last);
        bit took;
        in_valid = 1'b1;
        x        = xv;
        k        = kv;
        in_last  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_beat: in_ready stayed 0, required 1 within 200 cycles");
    endtask

    task automatic get_result(output res_t r);
        for (int i = 0; i < 200; i++) begin
            if (got_q.size() > 0) begin
                r = got_q.pop_front();
                return;
            end
            @(posedge clk);
            #1;
        end
        r = '{y: -999, ovf: 1'b0, ch: -1};
        checks++;
        errors++;
        $display("FAIL get_result: no result, required one within 200 cycles");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy) return;
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: busy stayed 1, required 0 within 300 cycles");
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (y !== 8'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", y); end
        checks++; if (y_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", y_ovf); end
        checks++; if (y_chunks !== 8'd0) begin errors++; $display("FAIL reset_chunks: got %0d want 0", y_chunks); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        cfg_shift = 5'd0;
        cfg_sat   = 1'b1;
        send_beat(V1234, ONES, 1'b1);
        // Capture edge counts as edge 1; the result shows after edge DEPTH+2 = 4.
        for (int e = 1; e <= 4; e++) begin
            if (e > 1) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (out_valid !== (e == 4)) begin
                errors++;
                $display("FAIL basic_latency edge %0d: out_valid got %b want %b", e, out_valid, e == 4);
            end
        end
        checks++; if ($signed(y) !== 10) begin errors++; $display("FAIL basic_y: got %0d want 10", $signed(y)); end
        checks++; if (y_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", y_ovf); end
        checks++; if (y_chunks !== 8'd1) begin errors++; $display("FAIL basic_chunks: got %0d want 1", y_chunks); end
        wait_idle();
        got_q.delete();
    endtask

    task automatic test_sat_wrap();
        res_t r;
        cfg_sat = 1'b1;
        send_beat({4{8'd127}}, {4{8'd127}}, 1'b1);
        get_result(r);
        checks++; if (r.y != 127) begin errors++; $display("FAIL sat_pos_y: got %0d want 127", r.y); end
        checks++; if (r.ovf !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf: got %b want 1", r.ovf); end
        wait_idle();
        cfg_sat = 1'b0;
        send_beat({4{8'd127}}, {4{8'd127}}, 1'b1);
        get_result(r);
        checks++; if (r.y != 4) begin errors++; $display("FAIL wrap_y: got %0d want 4", r.y); end
        checks++; if (r.ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf: got %b want 1", r.ovf); end
        wait_idle();
        cfg_sat = 1'b1;
        send_beat({4{8'h80}}, {4{8'd127}}, 1'b1);
        get_result(r);
        checks++; if (r.y != -128) begin errors++; $display("FAIL sat_neg_y: got %0d want -128", r.y); end
        checks++; if (r.ovf !== 1'b1) begin errors++; $display("FAIL sat_neg_ovf: got %b want 1", r.ovf); end
        wait_idle();
    endtask

    task automatic test_accum();
        res_t r;
        cfg_shift = 5'd0;
        cfg_sat   = 1'b1;
        send_beat(ONES, TWOS, 1'b0);
        send_beat(ONES, TWOS, 1'b1);
        get_result(r);
        checks++; if (r.y != 16) begin errors++; $display("FAIL accum_y: got %0d want 16", r.y); end
        checks++; if (r.ch != 2) begin errors++; $display("FAIL accum_chunks: got %0d want 2", r.ch); end
        wait_idle();
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL accum_extra: got %0d extra results want 0", got_q.size()); end
        send_beat(V1234, ONES, 1'b1);
        get_result(r);
        checks++; if (r.y != 10) begin errors++; $display("FAIL accum_fresh_y: got %0d want 10", r.y); end
        checks++; if (r.ch != 1) begin errors++; $display("FAIL accum_fresh_chunks: got %0d want 1", r.ch); end
        wait_idle();
    endtask

    task automatic test_shift();
        res_t r;
        cfg_shift = 5'd2;
        cfg_sat   = 1'b1;
        send_beat(V1234, ONES, 1'b1);
        get_result(r);
        checks++; if (r.y != 3) begin errors++; $display("FAIL shift_pos_y: got %0d want 3", r.y); end
        send_beat(32'hfcfdfeff, ONES, 1'b1);
        get_result(r);
        checks++; if (r.y != -2) begin errors++; $display("FAIL shift_neg_y: got %0d want -2", r.y); end
        wait_idle();
        cfg_shift = 5'd0;
    endtask

    task automatic test_back_to_back();
        int  nb = 0;
        bit  rdy;
        bit  exp_rdy;
        res_t r;
        cfg_shift = 5'd0;
        cfg_sat   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 3 && c <= 7);
            if (nb < 6) begin
                in_valid = 1'b1;
                x        = {4{8'(nb + 1)}};
                k        = ONES;
                in_last  = 1'b1;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
            rdy = in_ready;
            // First result is held from cycle 4 while out_ready is low through cycle 7.
            exp_rdy = !(c >= 4 && c <= 7);
            checks++;
            if (rdy !== exp_rdy) begin
                errors++;
                $display("FAIL b2b_in_ready cycle %0d: got %b want %b", c, rdy, exp_rdy);
            end
            if (rdy && in_valid) nb++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got_q.size() != 6) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 6", got_q.size());
        end
        for (int i = 0; i < 6 && got_q.size() > 0; i++) begin
            r = got_q.pop_front();
            checks++;
            if (r.y != 4 * (i + 1) || r.ch != 1) begin
                errors++;
                $display("FAIL b2b_result %0d: got y=%0d ch=%0d want y=%0d ch=1", i, r.y, r.ch, 4 * (i + 1));
            end
        end
        wait_idle();
        got_q.delete();
    endtask

    task automatic test_random();
        beat_t bq[$];
        res_t  eq[$];
        res_t  r;
        res_t  e;
        beat_t b;
        int    nexp;
        bit    rdy;
        longint s;
        for (int batch = 0; batch < 6; batch++) begin
            wait_idle();
            got_q.delete();
            bq.delete();
            eq.delete();
            cfg_shift = 5'($urandom_range(0, 12));
            cfg_sat   = 1'($urandom_range(0, 1));
            for (int v = 0; v < 8; v++) begin
                int nbeats = $urandom_range(1, 4);
                s = 0;
                for (int j = 0; j < nbeats; j++) begin
                    b.x    = $urandom;
                    b.k    = $urandom;
                    b.last = (j == nbeats - 1);
                    s += dot(b.x, b.k);
                    bq.push_back(b);
                end
                model(s, int'(cfg_shift), cfg_sat, e.y, e.ovf);
                e.ch = nbeats;
                eq.push_back(e);
            end
            nexp = eq.size();
            for (int c = 0; c < 2000; c++) begin
                if (bq.size() == 0 && got_q.size() >= nexp) break;
                out_ready = ($urandom_range(0, 3) != 0);
                if (bq.size() > 0) begin
                    in_valid = 1'b1;
                    x        = bq[0].x;
                    k        = bq[0].k;
                    in_last  = bq[0].last;
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
                @(negedge clk);
                rdy = in_ready;
                if (rdy && in_valid) void'(bq.pop_front());
                @(posedge clk);
                #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            checks++;
            if (got_q.size() != nexp) begin
                errors++;
                $display("FAIL rand_count batch %0d: got %0d results want %0d", batch, got_q.size(), nexp);
            end
            for (int i = 0; i < nexp && got_q.size() > 0; i++) begin
                r = got_q.pop_front();
                e = eq[i];
                checks++;
                if (r.y != e.y || r.ovf != e.ovf || r.ch != e.ch) begin
                    errors++;
                    $display("FAIL rand_result batch %0d idx %0d: got y=%0d ovf=%b ch=%0d want y=%0d ovf=%b ch=%0d",
                             batch, i, r.y, r.ovf, r.ch, e.y, e.ovf, e.ch);
                end
            end
        end
        wait_idle();
        got_q.delete();
    endtask

    task automatic test_chunk_sat();
        res_t r;
        int   ey;
        bit   eovf;
        cfg_shift = 5'd0;
        cfg_sat   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send_beat(32'h00000001, ONES, i == 299);
        end
        model(300, 0, 1'b0, ey, eovf);
        get_result(r);
        checks++; if (r.y != ey) begin errors++; $display("FAIL chunk_sat_y: got %0d want %0d", r.y, ey); end
        checks++; if (r.ovf != eovf) begin errors++; $display("FAIL chunk_sat_ovf: got %b want %b", r.ovf, eovf); end
        checks++; if (r.ch != 255) begin errors++; $display("FAIL chunk_sat_chunks: got %0d want 255", r.ch); end
        wait_idle();
        cfg_sat = 1'b1;
    endtask

    task automatic test_reset_mid();
        int   seen = 0;
        res_t r;
        cfg_shift = 5'd0;
        cfg_sat   = 1'b1;
        got_q.delete();
        send_beat(ONES, ONES, 1'b0);
        send_beat(V1234, ONES, 1'b1);
        send_beat(TWOS, ONES, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_output: got %0d valid cycles want 0", seen); end
        send_beat(V1234, ONES, 1'b1);
        get_result(r);
        checks++; if (r.y != 10) begin errors++; $display("FAIL rst_mid_y: got %0d want 10", r.y); end
        checks++; if (r.ch != 1) begin errors++; $display("FAIL rst_mid_chunks: got %0d want 1", r.ch); end
        wait_idle();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        x         = '0;
        k         = '0;
        cfg_shift = 5'd0;
        cfg_sat   = 1'b1;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_sat_wrap();
        test_accum();
        test_shift();
        test_back_to_back();
        test_random();
        test_chunk_sat();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
